// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - still-capture sequencer: setting snapshot, frame alignment, encoder start, crop windows
// Optional frame-count abort is enabled by defining CAPTURE_TIMEOUT_EN.
module capture_sequencer #(
   parameter int SENSOR_WIDTH   = 1288,
   parameter int CROP_SIZE      = 720,
   parameter int TIMEOUT_FRAMES = 4
) (
   input  logic        clock_in,
   input  logic        reset_n_in,
   input  logic        start_capture_in,
   input  logic        frame_valid_in,
   input  logic        line_valid_in,
   input  logic [9:0]  x_pan_in,
   input  logic [10:0] resolution_in,
   input  logic [1:0]  compression_factor_in,
   input  logic        encoder_image_valid_in,
   output logic        encoder_start_out,
   output logic [1:0]  compression_factor_out,
   output logic [10:0] x_size_out,
   output logic [10:0] y_size_out,
   output logic [10:0] pan_x_start_out,
   output logic [10:0] pan_x_end_out,
   output logic [10:0] zoom_start_out,
   output logic [10:0] zoom_end_out,
   output logic        busy_out,
   output logic        image_ready_out,
   output logic        timeout_out,
   output logic [10:0] line_count_out
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ARM      = 3'd1;
   localparam logic [2:0] S_WAIT_SOF = 3'd2;
   localparam logic [2:0] S_CAPTURE  = 3'd3;
   localparam logic [2:0] S_ENCODE   = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [10:0] CROP    = 11'(CROP_SIZE);
   localparam logic [10:0] PAN_MAX = 11'(SENSOR_WIDTH - CROP_SIZE);
   localparam logic [10:0] RES_MIN = 11'd16;

   logic [2:0]  state;
   logic        arm_first;
   logic        frame_valid_q;
   logic        line_valid_q;
   logic [10:0] res_q;
   logic [10:0] pan_q;
   logic [1:0]  cf_q;
   logic [10:0] line_count;
   logic [10:0] zoom_start;

   logic        fv_rise;
   logic        fv_fall;
   logic        lv_fall;
   logic        load_active;
   logic        abort;
   logic [10:0] res_round;
   logic [10:0] res_clean;
   logic [10:0] pan_ext;
   logic [10:0] pan_clean;

   assign fv_rise = frame_valid_in & ~frame_valid_q;
   assign fv_fall = ~frame_valid_in & frame_valid_q;
   assign lv_fall = ~line_valid_in & line_valid_q;

   // Settings are snapshotted between frames while idle, and once more on ARM entry.
   assign load_active = ((state == S_IDLE) && !frame_valid_in) || ((state == S_ARM) && arm_first);

   always_comb begin
      res_round = {resolution_in[10:4], 4'b0000};
      res_clean = res_round;
      if (res_round < RES_MIN) begin
         res_clean = RES_MIN;
      end else if (res_round > CROP) begin
         res_clean = CROP;
      end
      pan_ext   = {1'b0, x_pan_in};
      pan_clean = (pan_ext > PAN_MAX) ? PAN_MAX : pan_ext;
   end

`ifdef CAPTURE_TIMEOUT_EN
   logic [2:0] frame_count;
   logic       count_frame;
   logic       timeout_q;

   assign count_frame = fv_fall && !arm_first &&
                        ((state == S_ARM) || (state == S_WAIT_SOF) || (state == S_ENCODE));
   assign abort       = count_frame && (frame_count == 3'(TIMEOUT_FRAMES - 1));
   assign timeout_out = timeout_q;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         frame_count <= 3'd0;
         timeout_q   <= 1'b0;
      end else if (arm_first) begin
         frame_count <= 3'd0;
         timeout_q   <= 1'b0;
      end else if (count_frame) begin
         frame_count <= frame_count + 3'd1;
         if (abort) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign abort       = 1'b0;
   assign timeout_out = 1'b0;
`endif

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state             <= S_IDLE;
         arm_first         <= 1'b0;
         frame_valid_q     <= 1'b0;
         line_valid_q      <= 1'b0;
         res_q             <= 11'd512;
         pan_q             <= 11'd284;
         cf_q              <= 2'd0;
         encoder_start_out <= 1'b0;
         image_ready_out   <= 1'b0;
         line_count        <= 11'd0;
         line_count_out    <= 11'd0;
      end else begin
         frame_valid_q     <= frame_valid_in;
         line_valid_q      <= line_valid_in;
         encoder_start_out <= 1'b0;
         arm_first         <= 1'b0;
         if (load_active) begin
            res_q <= res_clean;
            pan_q <= pan_clean;
            cf_q  <= compression_factor_in;
         end
         case (state)
            S_IDLE: begin
               if (start_capture_in) begin
                  state     <= S_ARM;
                  arm_first <= 1'b1;
               end
            end
            S_ARM: begin
               if (arm_first) begin
                  image_ready_out <= 1'b0;
                  line_count      <= 11'd0;
               end
               // Low here means either no frame at entry or the running frame has just ended.
               if (abort) begin
                  state <= S_IDLE;
               end else if (!frame_valid_in) begin
                  state             <= S_WAIT_SOF;
                  encoder_start_out <= 1'b1;
               end
            end
            S_WAIT_SOF: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (fv_rise) begin
                  state <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (lv_fall && (line_count != 11'h7FF)) begin
                  line_count <= line_count + 11'd1;
               end
               if (fv_fall) begin
                  state <= S_ENCODE;
               end
            end
            S_ENCODE: begin
               if (encoder_image_valid_in) begin
                  state           <= S_DONE;
                  image_ready_out <= 1'b1;
                  line_count_out  <= line_count;
               end else if (abort) begin
                  state <= S_IDLE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign zoom_start             = (CROP - res_q) >> 1;
   assign zoom_start_out         = zoom_start;
   assign zoom_end_out           = zoom_start + res_q;
   assign pan_x_start_out        = pan_q;
   assign pan_x_end_out          = pan_q + CROP;
   assign x_size_out             = res_q;
   assign y_size_out             = res_q;
   assign compression_factor_out = cf_q;
   assign busy_out               = (state == S_ARM) || (state == S_WAIT_SOF) ||
                                   (state == S_CAPTURE) || (state == S_ENCODE);

endmodule
